// File: rtl/y_alu_arbiter_if.sv
// ============================================================================
//  Module   : y_alu_arbiter_if
//  Brief    : Request/response bundle between two ALU clients and the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface y_alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    logic             res0_valid;
    logic             res0_ready;
    logic             res1_valid;
    logic             res1_ready;
    logic [WIDTH-1:0] res_z;
    logic             res_err;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output res0_ready, res1_ready,
        input  req0_ready, req1_ready,
        input  res0_valid, res1_valid, res_z, res_err, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  res0_ready, res1_ready,
        output req0_ready, req1_ready,
        output res0_valid, res1_valid, res_z, res_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/y_alu_arbiter.sv
// ============================================================================
//  Module   : y_alu_arbiter
//  Brief    : Two-requester round-robin arbiter/sequencer for a shared ALU.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module y_alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  wire logic      clk,
    input  wire logic      reset,
    y_alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b110;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_prio;
    logic             r_owner;
    logic             r_busy;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_z;
    logic             r_err;

    logic             w_any;
    logic             w_gnt_id;
    logic             w_grant;
    logic             w_owner_rdy;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [2:0]       w_sel_op;
    logic [WIDTH-1:0] w_alu_z;
    logic             w_alu_err;

    // Arbitration: a lone requester wins outright; on contention prio decides.
    always_comb begin
        w_any    = bus.req0_valid | bus.req1_valid;
        w_gnt_id = (bus.req0_valid & bus.req1_valid) ? r_prio : bus.req1_valid;
        w_grant  = (r_state == S_IDLE) && w_any && !reset;
        w_sel_a  = w_gnt_id ? bus.req1_a  : bus.req0_a;
        w_sel_b  = w_gnt_id ? bus.req1_b  : bus.req0_b;
        w_sel_op = w_gnt_id ? bus.req1_op : bus.req0_op;
    end

    assign w_owner_rdy = r_owner ? bus.res1_ready : bus.res0_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (w_owner_rdy) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_alu_z   = '0;
        w_alu_err = 1'b0;
        case (r_op)
            c_OP_AND: w_alu_z = r_a & r_b;
            c_OP_OR:  w_alu_z = r_a | r_b;
            c_OP_ADD: w_alu_z = r_a + r_b;
            c_OP_SUB: w_alu_z = r_a - r_b;
            default:  w_alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
            r_busy  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_z     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_grant) begin
                r_a     <= w_sel_a;
                r_b     <= w_sel_b;
                r_op    <= w_sel_op;
                r_owner <= w_gnt_id;
                r_prio  <= ~w_gnt_id;
            end
            if (r_state == S_EXEC) begin
                r_z   <= w_alu_z;
                r_err <= w_alu_err;
            end
        end
    end

    assign bus.req0_ready = w_grant && !w_gnt_id;
    assign bus.req1_ready = w_grant &&  w_gnt_id;
    assign bus.res0_valid = (r_state == S_RESP) && !r_owner;
    assign bus.res1_valid = (r_state == S_RESP) &&  r_owner;
    assign bus.res_z      = r_z;
    assign bus.res_err    = r_err;
    assign bus.busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_y_alu_arbiter.sv
// ============================================================================
//  Module   : tb_y_alu_arbiter
//  Brief    : Scoreboard bench for y_alu_arbiter with a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_y_alu_arbiter;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    y_alu_arbiter_if #(.WIDTH(W)) bus();

    y_alu_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] z;
        logic         err;
    } exp_t;

    typedef enum int {M_IDLE, M_EXEC, M_RESP} mst_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    mst_t m_st     = M_IDLE;
    logic m_prio   = 1'b0;
    logic m_own    = 1'b0;
    bit   post_rst = 1'b0;
    bit   rand_rdy = 1'b0;

    function automatic exp_t ref_model(input logic id, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [2:0] op);
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        e.z   = '0;
        case (op)
            3'd0:    e.z = a & b;
            3'd1:    e.z = a | b;
            3'd2:    e.z = a + b;
            3'd6:    e.z = a - b;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: transaction model of grant order, latency and result routing.
    initial begin
        logic gid, e0, e1;
        mst_t nxt;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("ready_during_reset", W'({bus.req1_ready, bus.req0_ready}), '0);
                m_st     = M_IDLE;
                m_prio   = 1'b0;
                sb.delete();
                post_rst = 1'b1;
            end else begin
                nxt = m_st;
                if (post_rst) begin
                    chk("reset_res_z", bus.res_z, '0);
                    chk("reset_res_err", W'(bus.res_err), '0);
                    post_rst = 1'b0;
                end
                chk("busy", W'(bus.busy), W'(m_st != M_IDLE));
                e0 = 1'b0;
                e1 = 1'b0;
                if (m_st == M_IDLE && (bus.req0_valid || bus.req1_valid)) begin
                    gid = (bus.req0_valid && bus.req1_valid) ? m_prio : bus.req1_valid;
                    e0  = !gid;
                    e1  = gid;
                    sb.push_back(gid ? ref_model(1'b1, bus.req1_a, bus.req1_b, bus.req1_op)
                                     : ref_model(1'b0, bus.req0_a, bus.req0_b, bus.req0_op));
                    m_prio = !gid;
                    m_own  = gid;
                    nxt    = M_EXEC;
                end
                chk("req0_ready", W'(bus.req0_ready), W'(e0));
                chk("req1_ready", W'(bus.req1_ready), W'(e1));
                chk("res0_valid", W'(bus.res0_valid), W'(m_st == M_RESP && !m_own));
                chk("res1_valid", W'(bus.res1_valid), W'(m_st == M_RESP &&  m_own));
                if (bus.res0_valid || bus.res1_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: actual=valid required=none at %0t", $time);
                    end else begin
                        chk("res_owner", W'(bus.res1_valid), W'(sb[0].id));
                        chk("res_z", bus.res_z, sb[0].z);
                        chk("res_err", W'(bus.res_err), W'(sb[0].err));
                        if ((bus.res0_valid && bus.res0_ready) || (bus.res1_valid && bus.res1_ready))
                            void'(sb.pop_front());
                    end
                end
                if (m_st == M_EXEC) nxt = M_RESP;
                if (m_st == M_RESP && (m_own ? bus.res1_ready : bus.res0_ready)) nxt = M_IDLE;
                m_st = nxt;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) begin
            bus.res0_ready = ($urandom % 4) != 0;
            bus.res1_ready = ($urandom % 4) != 0;
        end
    end

    task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = id ? bus.req1_ready : bus.req0_ready;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout: actual=no_ready required=ready requester=%0d", id);
        end
        @(posedge clk); #1;
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    task automatic rand_ops(input bit id, input int n);
        logic [W-1:0] a, b;
        logic [2:0]   op;
        for (int k = 0; k < n; k++) begin
            a = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : W'($urandom);
            b = ($urandom % 4 == 0) ? 32'h0000_0001 : W'($urandom);
            case ($urandom % 5)
                0:       op = 3'd0;
                1:       op = 3'd1;
                2:       op = 3'd2;
                3:       op = 3'd6;
                default: op = 3'($urandom);
            endcase
            issue(id, a, b, op);
            repeat ($urandom % 3) @(posedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.res0_ready = 1'b1; bus.res1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        issue(1'b0, 32'd5, 32'd3, 3'b010);
        issue(1'b1, 32'd0, 32'd1, 3'b110);
        issue(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b010);
        issue(1'b0, 32'hF0, 32'h0F, 3'b011);
        issue(1'b1, 32'hF0, 32'h0F, 3'b000);
        issue(1'b0, 32'hF0, 32'h0F, 3'b001);

        // Contention: both requesters keep asking; grants must alternate.
        fork
            for (int k = 0; k < 4; k++) issue(1'b0, W'($urandom), W'($urandom), 3'b010);
            for (int k = 0; k < 4; k++) issue(1'b1, W'($urandom), W'($urandom), 3'b110);
        join

        // Backpressure on requester 0 while requester 1 waits.
        repeat (3) @(posedge clk);
        #1 bus.res0_ready = 1'b0;
        fork
            issue(1'b0, 32'd10, 32'd20, 3'b010);
            begin @(posedge clk); issue(1'b1, 32'd7, 32'd9, 3'b001); end
            begin repeat (8) @(posedge clk); #1 bus.res0_ready = 1'b1; end
        join

        rand_rdy = 1'b1;
        fork
            rand_ops(1'b0, 30);
            rand_ops(1'b1, 30);
        join
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        bus.res0_ready = 1'b1;
        bus.res1_ready = 1'b1;
        repeat (6) @(posedge clk);

        // Reset while the granted operation sits in EXEC.
        issue(1'b1, 32'd100, 32'd1, 3'b010);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        issue(1'b1, 32'd40, 32'd2, 3'b110);
        repeat (6) @(posedge clk);

        chk("scoreboard_drained", W'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
